// File: rtl/router_pkg.sv
// Shared router definitions: default widths, port FSM states, legal idle-gap range.
package router_pkg;

    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned DATA_W_DEF = 32;

    // Idle gap between frames must stay within what the receiver can resynchronise on.
    localparam int unsigned GAP_MIN = 1;
    localparam int unsigned GAP_MAX = 15;

    // Port FSM states, also decoded by the portin-side debug logic.
    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StLast,
        StGap
    } port_state_e;

    // Saturate an idle-gap setting into the legal range.
    function automatic int unsigned gap_clamp(input int unsigned g);
        if (g < GAP_MIN) return GAP_MIN;
        if (g > GAP_MAX) return GAP_MAX;
        return g;
    endfunction

endpackage

// File: rtl/portout_holdbuf.sv
// Single-entry holding register with valid/ready load side and an unload strobe.
module portout_holdbuf
    import router_pkg::*;
#(
    parameter int unsigned W = ADDR_W_DEF + DATA_W_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [W-1:0] load_data,
    input  logic         unload,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Next-state: clear wins, then load into an empty slot, then unload.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (clear) begin
            full_d = 1'b0;
        end else if (load_valid && !full_q) begin
            full_d = 1'b1;
            data_d = load_data;
        end else if (unload) begin
            full_d = 1'b0;
        end
    end

    // Entry storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign load_ready = !full_q;
    assign full       = full_q;
    assign data       = data_q;

endmodule

// File: rtl/portout.sv
// Router output-port serializer: packet in, frame_n/valid_n/dout serial frame out.
module portout
    import router_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned GAP    = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_payload,
    output logic              in_ready,
    output logic              frame_n,
    output logic              valid_n,
    output logic              dout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PktW   = ADDR_W + DATA_W;
    localparam int unsigned GapCyc = gap_clamp(GAP);
    // Counter must also reach the largest legal gap.
    localparam int unsigned CntW   = ($clog2(DATA_W) > 4) ? $clog2(DATA_W) : 4;

    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_W - 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 2);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapCyc - 1);

    port_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic              frame_n_q, frame_n_d;
    logic              valid_n_q, valid_n_d;
    logic              dout_q, dout_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic              launch;
    logic              buf_full;
    logic [PktW-1:0]   buf_data;

    portout_holdbuf #(
        .W (PktW)
    ) u_holdbuf (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .load_valid (in_valid),
        .load_ready (in_ready),
        .load_data  ({in_addr, in_payload}),
        .unload     (launch),
        .full       (buf_full),
        .data       (buf_data)
    );

    // Next-state, shift and launch decisions; outputs are decoded from the next state so
    // every serial pin comes straight from a flop.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_sh_d = addr_sh_q;
        data_sh_d = data_sh_q;
        launch    = 1'b0;

        if (clear) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (buf_full) launch = 1'b1;
                end
                StAddr: begin
                    addr_sh_d = addr_sh_q >> 1;
                    if (cnt_q == AddrLast) begin
                        state_d = StData;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StData: begin
                    data_sh_d = data_sh_q >> 1;
                    if (cnt_q == DataLast) begin
                        state_d = StLast;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StLast: begin
                    state_d = StGap;
                    cnt_d   = '0;
                end
                StGap: begin
                    if (cnt_q == GapLast) begin
                        // A queued packet starts right after the gap without an idle cycle.
                        if (buf_full) launch = 1'b1;
                        else          state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        if (launch) begin
            state_d                = StAddr;
            cnt_d                  = '0;
            {addr_sh_d, data_sh_d} = buf_data;
        end

        frame_n_d = !(state_d == StAddr || state_d == StData);
        valid_n_d = !(state_d == StData || state_d == StLast);
        done_d    = (state_d == StLast);
        busy_d    = (state_d != StIdle);
        if (state_d == StAddr) begin
            dout_d = addr_sh_d[0];
        end else if (state_d == StData || state_d == StLast) begin
            dout_d = data_sh_d[0];
        end else begin
            dout_d = 1'b0;
        end
    end

    // State, counter, shift registers and registered serial outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_sh_q <= '0;
            data_sh_q <= '0;
            frame_n_q <= 1'b1;
            valid_n_q <= 1'b1;
            dout_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_sh_q <= addr_sh_d;
            data_sh_q <= data_sh_d;
            frame_n_q <= frame_n_d;
            valid_n_q <= valid_n_d;
            dout_q    <= dout_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign frame_n = frame_n_q;
    assign valid_n = valid_n_q;
    assign dout    = dout_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: doc/portout.md
# portout

Router output-port serializer: the transmit end of the router's serial port protocol. Accepts a parallel {addr, payload} packet through a valid/ready handshake, holds up to one queued packet, and drives the serial frame_n / valid_n / dout lines to a downstream port input. Frame format: address phase, payload phase, last-bit marker, then mandatory idle gap.

## Interface
- ADDR_W, 4, destination address width (bits sent in address phase)
- DATA_W, 32, payload width
- GAP, 1, idle cycles (frame_n=1, valid_n=1) after every frame; legal range 1..15
- clock  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- clear  input  1  synchronous abort: drop in-flight frame and queued packet
- in_valid  input  1  packet offered
- in_addr  input  ADDR_W  destination address
- in_payload  input  DATA_W  payload word
- in_ready  output  1  packet accepted on edge where in_valid && in_ready
- frame_n  output  1  active-low frame envelope
- valid_n  output  1  active-low payload-bit qualifier
- dout  output  1  serial data, LSB first
- busy  output  1  frame or gap in progress
- done  output  1  one-cycle pulse coincident with last-bit cycle

## Operation
- Holding buffer: one entry. in_ready = !buf_full. Accept loads buffer. Buffer empties when FSM launches it; in_ready rises the cycle after launch.
- FSM states: IDLE, ADDR, DATA, LAST, GAP. Bit counter width clog2(DATA_W).
- IDLE: frame_n=1, valid_n=1, dout=0. If buf_full: load shift registers from buffer, clear buf_full, go ADDR.
- ADDR: frame_n=0, valid_n=1, dout=addr[i], i=0..ADDR_W-1, one bit per cycle; then DATA.
- DATA: frame_n=0, valid_n=0, dout=payload[i], i=0..DATA_W-2; then LAST.
- LAST: frame_n=1, valid_n=0, dout=payload[DATA_W-1], done=1; then GAP.
- GAP: frame_n=1, valid_n=1, dout=0 for GAP cycles. At final gap cycle, if buf_full launch directly into ADDR (no IDLE visit); else IDLE.
- busy=1 in ADDR, DATA, LAST, GAP.
- Accept during any state allowed while buffer empty; packet is never modified after acceptance.
- clear (reset not asserted): next edge forces IDLE, empties buffer, frame_n=1, valid_n=1, dout=0, done=0; takes priority over accept and launch on that edge. Receiver sees frame_n=1,valid_n=1 and discards partial frame.
- reset mid-frame: outputs return to reset values asynchronously; no done pulse.

## Timing
- Reset values: frame_n=1, valid_n=1, dout=0, done=0, busy=0, in_ready=1.
- All serial outputs and done are registered (no combinational path from inputs).
- Accept at edge k with FSM in IDLE: buffer full after k; first ADDR cycle visible after edge k+1; in_ready high again after k+1.
- Frame length: ADDR_W + (DATA_W-1) + 1 cycles = 36 at defaults; period between back-to-back frame starts = 36 + GAP.
- done high exactly one cycle, same cycle as LAST; receiver's vld follows one cycle later.
- Simultaneous accept and launch cannot occur (in_ready low while buffer full).

## Structure
- Shared package router_pkg: ADDR_W/DATA_W defaults, port FSM state enum (shared with portin-side debug), GAP range check constant.
- One sub-module natural: portout_holdbuf (single-entry valid/ready register, load/unload). FSM, counter, shift registers stay in portout.

## Test plan
- Reset then idle 10 cycles -> frame_n=1, valid_n=1, dout=0, in_ready=1, busy=0 throughout.
- Send addr=4'hA, payload=32'h8000_0001 -> dout sequence 0,1,0,1 with valid_n=1; then 1,0…0 (31 bits) with valid_n=0; LAST dout=1, frame_n=1; done pulse once; looped-back portin yields addr=A, payload=8000_0001.
- Two packets offered back-to-back, GAP=1 -> second accepted during first frame, in_ready low until launch, second frame starts exactly 37 cycles after first.
- GAP=3, single packet -> exactly 3 idle cycles before busy falls.
- clear asserted in DATA cycle 10 with queued packet -> next cycle idle outputs, buffer empty, no done, queued packet dropped.
- reset asserted mid-ADDR -> outputs at reset values before next edge; subsequent packet transmits normally.
